// File: rtl/fpu_pkg.sv
// fpu_pkg: constants and FSM state type shared by the FPU significand blocks.
//   FN_W     : width of the left-aligned significand product bus
//   DP_SIG_W : double-precision significand width (hidden bit included)
//   SP_SIG_W : single-precision significand width (hidden bit included)
//   CNT_W    : iteration counter width, large enough to hold DP_SIG_W
package fpu_pkg;

  localparam int FN_W     = 128;
  localparam int DP_SIG_W = 53;
  localparam int SP_SIG_W = 24;
  localparam int CNT_W    = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/sig_mul_seq.sv
// sig_mul_seq: sequential radix-2 shift-add significand multiplier.
// One multiplier bit is consumed per RUN cycle (LSB first), so a double
// takes 53 RUN cycles and a single 24. The exact product is left-aligned
// onto fn for the rounder.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request a multiply (sampled only in IDLE)
//   abort  : synchronous cancel of a running multiply
//   db     : 1 = double (53-bit operands), 0 = single (24-bit operands)
//   fa, fb : multiplicand / multiplier significands
//   busy   : high in RUN and DONE
//   done   : one-cycle pulse, fn/db_o hold a new result
//   fn     : left-aligned significand product
//   db_o   : precision captured with the operation, valid with fn
module sig_mul_seq #(
  parameter int FN_W  = fpu_pkg::FN_W,
  parameter int SIG_W = fpu_pkg::DP_SIG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             db,
  input  logic [SIG_W-1:0] fa,
  input  logic [SIG_W-1:0] fb,
  output logic             busy,
  output logic             done,
  output logic [FN_W-1:0]  fn,
  output logic             db_o
);

  import fpu_pkg::*;

  localparam int ACC_W = 2 * SIG_W;
  localparam logic [SIG_W-1:0] SP_MASK = SIG_W'({SP_SIG_W{1'b1}});
  localparam logic [CNT_W-1:0] W_DP    = CNT_W'(DP_SIG_W);
  localparam logic [CNT_W-1:0] W_SP    = CNT_W'(SP_SIG_W);

  fsm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] mcand_q, mcand_d;
  logic [SIG_W-1:0] mplier_q, mplier_d;
  logic             db_q, db_d;
  logic [FN_W-1:0]  fn_q, fn_d;
  logic             db_o_q, db_o_d;

  logic             accept;
  logic             last_step;
  logic [FN_W-1:0]  prod_ext;

  // abort takes priority over start in the same IDLE cycle
  assign accept    = (state_q == ST_IDLE) && start && !abort;
  assign last_step = (state_q == ST_RUN) && !abort && (cnt_q <= CNT_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN: begin
        if (abort)          state_d = ST_IDLE;
        else if (last_step) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  // Datapath next values
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    db_d     = db_q;
    fn_d     = fn_q;
    db_o_d   = db_o_q;
    prod_ext = '0;

    if (accept) begin
      // Single operands only use the low 24 bits; upper bits are don't-care.
      mcand_d  = {{SIG_W{1'b0}}, (db ? fa : (fa & SP_MASK))};
      mplier_d = db ? fb : (fb & SP_MASK);
      db_d     = db;
      acc_d    = '0;
      cnt_d    = db ? W_DP : W_SP;
    end else if ((state_q == ST_RUN) && !abort) begin
      // The multiplicand is pre-shifted so each step adds fa * 2^i.
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
      if (last_step) begin
        // Left-align: a 2w-bit product shifted up by FN_W - 2w.
        prod_ext = FN_W'(acc_d);
        fn_d     = db_q ? (prod_ext << (FN_W - 2 * DP_SIG_W))
                        : (prod_ext << (FN_W - 2 * SP_SIG_W));
        db_o_d   = db_q;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      db_q     <= 1'b0;
      fn_q     <= '0;
      db_o_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      db_q     <= db_d;
      fn_q     <= fn_d;
      db_o_q   <= db_o_d;
    end
  end

  assign fn   = fn_q;
  assign db_o = db_o_q;

endmodule

// File: tb/tb_sig_mul_seq.sv
// tb_sig_mul_seq: scoreboard bench for sig_mul_seq. Stimulus pushes the
// expected result of every operation that should complete; a monitor pops
// and compares whenever done is seen.
module tb_sig_mul_seq;

  typedef struct {
    logic [127:0] fn;
    logic         db;
    int           lat;
    int           issue;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic         db;
  logic [52:0]  fa;
  logic [52:0]  fb;
  logic         busy;
  logic         done;
  logic [127:0] fn;
  logic         db_o;

  int   cyc;
  int   checks;
  int   errors;
  exp_t sbq[$];

  localparam logic [52:0]  ONE_D  = 53'h10000000000000;
  localparam logic [52:0]  MAX_D  = 53'h1FFFFFFFFFFFFF;
  localparam logic [52:0]  GARB_S = 53'h1FFFFFFFC00000;  // 1.5 single, junk above bit 23
  localparam logic [127:0] FN_ONE = 128'h4000_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] FN_15S = 128'h9000_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] FN_MAX = ((128'd1 << 106) - (128'd1 << 54) + 128'd1) << 22;
  localparam logic [127:0] FN_3X5 = 128'h0000_0000_0000_0000_0000_0000_03C0_0000;
  localparam logic [127:0] FN_S2  = 128'h0000_0100_0002_0000_0000_0000_0000_0000;

  sig_mul_seq #(.FN_W(128), .SIG_W(53)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .db    (db),
    .fa    (fa),
    .fb    (fb),
    .busy  (busy),
    .done  (done),
    .fn    (fn),
    .db_o  (db_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
        end else begin
          e = sbq.pop_front();
          chk("fn", fn, e.fn);
          chk("db_o", 128'(db_o), 128'(e.db));
          chk("latency", 128'(cyc - e.issue), 128'(e.lat));
        end
      end
    end
  endtask

  task automatic issue(input logic d, input logic [52:0] a, input logic [52:0] b,
                       input bit push, input logic [127:0] efn);
    exp_t e;
    @(negedge clk);
    db = d; fa = a; fb = b; start = 1'b1;
    if (push) begin
      e.fn = efn; e.db = d; e.lat = d ? 54 : 25; e.issue = cyc;
      sbq.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((sbq.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending after %0d cycles expected 0", name, sbq.size(), budget);
      sbq.delete();
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
    end
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; db = 1'b0; fa = '0; fb = '0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_fn", fn, 128'd0);
    chk("rst_db_o", 128'(db_o), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed products
    issue(1'b1, ONE_D, ONE_D, 1, FN_ONE);            drain("d_one", 200);
    issue(1'b0, GARB_S, 53'hC00000, 1, FN_15S);      drain("s_15", 200);
    issue(1'b1, MAX_D, MAX_D, 1, FN_MAX);            drain("d_max", 200);
    issue(1'b1, 53'd3, 53'd5, 1, FN_3X5);            drain("d_3x5", 200);
    issue(1'b0, 53'h800001, 53'h2, 1, FN_S2);        drain("s_odd", 200);
    issue(1'b1, 53'd0, MAX_D, 1, 128'd0);            drain("d_zero", 200);
    chk("fn_hold", fn, 128'd0);

    // Abort in RUN after a known prior result
    issue(1'b1, ONE_D, ONE_D, 1, FN_ONE);            drain("pre_abort", 200);
    issue(1'b1, MAX_D, MAX_D, 0, 128'd0);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_fn", fn, FN_ONE);
    chk("abort_db_o", 128'(db_o), 128'd1);
    // abort beats start in IDLE
    start = 1'b1; abort = 1'b1; db = 1'b0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", 128'(busy), 128'd0);
    issue(1'b0, 53'hC00000, 53'hC00000, 1, FN_15S); drain("post_abort", 200);

    // Start pulses during RUN and DONE are ignored
    issue(1'b1, 53'd3, 53'd5, 1, FN_3X5);
    repeat (5) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done("ign", 100);
    start = 1'b1; @(negedge clk); start = 1'b0;
    drain("ign", 200);
    repeat (70) @(negedge clk);
    chk("ign_idle_busy", 128'(busy), 128'd0);

    // Reset in the middle of RUN
    issue(1'b1, MAX_D, MAX_D, 0, 128'd0);
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_done", 128'(done), 128'd0);
    chk("midrst_fn", fn, 128'd0);
    chk("midrst_db_o", 128'(db_o), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (70) @(negedge clk);
    chk("midrst_noresume", 128'(busy), 128'd0);
    issue(1'b1, ONE_D, ONE_D, 1, FN_ONE);            drain("post_rst", 200);

    // Back-to-back with start held high; latency check implies a 55-cycle period
    begin
      exp_t e;
      logic [52:0]  a_t [3];
      logic [52:0]  b_t [3];
      logic [127:0] f_t [3];
      a_t[0] = ONE_D;  b_t[0] = ONE_D;  f_t[0] = FN_ONE;
      a_t[1] = 53'd3;  b_t[1] = 53'd5;  f_t[1] = FN_3X5;
      a_t[2] = MAX_D;  b_t[2] = MAX_D;  f_t[2] = FN_MAX;
      @(negedge clk);
      db = 1'b1; fa = a_t[0]; fb = b_t[0]; start = 1'b1;
      e.fn = f_t[0]; e.db = 1'b1; e.lat = 54; e.issue = cyc;
      sbq.push_back(e);
      for (int k = 1; k < 3; k++) begin
        wait_done("b2b", 100);
        fa = a_t[k]; fb = b_t[k];
        e.fn = f_t[k]; e.db = 1'b1; e.lat = 54; e.issue = cyc + 1;
        sbq.push_back(e);
      end
      repeat (2) @(negedge clk);
      start = 1'b0;
      drain("b2b", 300);
    end

    repeat (5) @(negedge clk);
    chk("final_busy", 128'(busy), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
